// File: rtl/trap_pkg.sv
// Shared types and constants for the M-mode trap controller: cause codes,
// FSM states, tval source selector and the event flag bundle.
package trap_pkg;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_LD_MIS  = 32'd4;
    localparam logic [31:0] CAUSE_LD_FLT  = 32'd5;
    localparam logic [31:0] CAUSE_ST_MIS  = 32'd6;
    localparam logic [31:0] CAUSE_ST_FLT  = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE = 3;
    localparam int unsigned CAUSE_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP,
        ST_MRET,
        ST_REDIR,
        ST_FLUSH
    } state_e;

    typedef enum logic [1:0] {
        TVAL_ZERO,
        TVAL_INST,
        TVAL_PC,
        TVAL_ADDR
    } tval_sel_e;

    typedef struct packed {
        logic illegal;
        logic ebreak;
        logic ecall;
        logic ld_mis;
        logic st_mis;
        logic ld_flt;
        logic st_flt;
        logic mret;
        logic ext_irq;
        logic tmr_irq;
        logic mie;
    } trap_flags_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority selection of one trap event; mret ranks below all
// exceptions and above the (MIE-gated) interrupts.
module trap_prio_enc
    import trap_pkg::*;
(
    input  trap_flags_t             flags_i,
    output logic                    hit_o,
    output logic                    mret_o,
    output logic [CAUSE_W-1:0]      cause_o,
    output tval_sel_e               tval_sel_o
);

    always_comb begin
        hit_o      = 1'b0;
        mret_o     = 1'b0;
        cause_o    = '0;
        tval_sel_o = TVAL_ZERO;
        if (flags_i.illegal) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_ILLEGAL;
            tval_sel_o = TVAL_INST;
        end else if (flags_i.ebreak) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_EBREAK;
            tval_sel_o = TVAL_PC;
        end else if (flags_i.ecall) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_ECALL_M;
        end else if (flags_i.ld_mis) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_LD_MIS;
            tval_sel_o = TVAL_ADDR;
        end else if (flags_i.st_mis) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_ST_MIS;
            tval_sel_o = TVAL_ADDR;
        end else if (flags_i.ld_flt) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_LD_FLT;
            tval_sel_o = TVAL_ADDR;
        end else if (flags_i.st_flt) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_ST_FLT;
            tval_sel_o = TVAL_ADDR;
        end else if (flags_i.mret) begin
            mret_o     = 1'b1;
        end else if (flags_i.ext_irq && flags_i.mie) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_M_EXT;
        end else if (flags_i.tmr_irq && flags_i.mie) begin
            hit_o      = 1'b1;
            cause_o    = CAUSE_M_TIMER;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: CSR update strobe, pipeline flush and fetch
// redirect. Optional macro TRAP_CTRL_VECTORED_EN enables vectored interrupts.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [31:0]     mem_inst_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            exc_illegal_i,
    input  logic            exc_ecall_i,
    input  logic            exc_ebreak_i,
    input  logic            exc_ld_mis_i,
    input  logic            exc_st_mis_i,
    input  logic            exc_ld_flt_i,
    input  logic            exc_st_flt_i,
    input  logic            mret_i,
    input  logic            ext_irq_i,
    input  logic            tmr_irq_i,
    input  logic            csr_w_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mcause_i,
    input  logic [XLEN-1:0] csr_mtval_i,
    output logic            is_trap_o,
    output logic            is_mret_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = 2;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    cause_q, cause_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [XLEN-1:0]    ret_pc_q, ret_pc_d;
    logic               from_mret_q, from_mret_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    trap_flags_t        flags;
    logic               enc_hit;
    logic               enc_mret;
    logic [CAUSE_W-1:0] enc_cause;
    tval_sel_e          enc_tval_sel;
    logic [XLEN-1:0]    tvec_base;
    logic [XLEN-1:0]    trap_target;

    assign flags = '{
        illegal: exc_illegal_i,
        ebreak:  exc_ebreak_i,
        ecall:   exc_ecall_i,
        ld_mis:  exc_ld_mis_i,
        st_mis:  exc_st_mis_i,
        ld_flt:  exc_ld_flt_i,
        st_flt:  exc_st_flt_i,
        mret:    mret_i,
        ext_irq: ext_irq_i,
        tmr_irq: tmr_irq_i,
        mie:     mstatus_i[MSTATUS_MIE]
    };

    trap_prio_enc u_prio_enc (
        .flags_i    (flags),
        .hit_o      (enc_hit),
        .mret_o     (enc_mret),
        .cause_o    (enc_cause),
        .tval_sel_o (enc_tval_sel)
    );

    assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    // Vectored mode offsets interrupts only; exceptions always land on base.
    always_comb begin
        trap_target = tvec_base;
        if ((mtvec_i[1:0] == 2'b01) && cause_q[XLEN-1]) begin
            trap_target = tvec_base + (XLEN'(cause_q[XLEN-2:0]) << 2);
        end
    end
`else
    assign trap_target = tvec_base;
`endif

    logic unused_ok;
    assign unused_ok = ^{mstatus_i, mtvec_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mepc_q      <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            ret_pc_q    <= '0;
            from_mret_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mepc_q      <= mepc_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            ret_pc_q    <= ret_pc_d;
            from_mret_q <= from_mret_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        mepc_d        = mepc_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        ret_pc_d      = ret_pc_q;
        from_mret_d   = from_mret_q;
        cnt_d         = cnt_q;
        is_trap_o     = 1'b0;
        is_mret_o     = 1'b0;
        mepc_o        = '0;
        mcause_o      = '0;
        mtval_o       = '0;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid_i && enc_hit) begin
                    state_d     = ST_TRAP;
                    from_mret_d = 1'b0;
                    mepc_d      = mem_pc_i;
                    cause_d     = XLEN'(enc_cause);
                    unique case (enc_tval_sel)
                        TVAL_INST: tval_d = XLEN'(mem_inst_i);
                        TVAL_PC:   tval_d = mem_pc_i;
                        TVAL_ADDR: tval_d = mem_addr_i;
                        default:   tval_d = '0;
                    endcase
                end else if (mem_valid_i && enc_mret) begin
                    state_d     = ST_MRET;
                    from_mret_d = 1'b1;
                end
            end
            ST_TRAP: begin
                is_trap_o = 1'b1;
                stall_o   = 1'b1;
                flush_o   = 1'b1;
                mepc_o    = mepc_q;
                mcause_o  = cause_q;
                mtval_o   = tval_q;
                // A committing CSR write wins the CSR port; retry next cycle.
                if (!csr_w_i) begin
                    state_d = ST_REDIR;
                end
            end
            ST_MRET: begin
                is_mret_o = 1'b1;
                stall_o   = 1'b1;
                flush_o   = 1'b1;
                mepc_o    = csr_mepc_i;
                mcause_o  = csr_mcause_i;
                mtval_o   = csr_mtval_i;
                if (!csr_w_i) begin
                    state_d  = ST_REDIR;
                    ret_pc_d = csr_mepc_i;
                end
            end
            ST_REDIR: begin
                redirect_o    = 1'b1;
                flush_o       = 1'b1;
                redirect_pc_o = from_mret_q ? ret_pc_q : trap_target;
                if (FLUSH_CYCLES > 0) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table with a scoreboard queue
// plus hand-written csr_w collision and mid-trap reset sequences.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FLUSH_CYCLES = 1;
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_TRAP = 2'd1;
    localparam logic [1:0] K_MRET = 2'd2;
`ifdef TRAP_CTRL_VECTORED_EN
    localparam logic [31:0] VEC_TMR_TGT = 32'h0000_021C;
`else
    localparam logic [31:0] VEC_TMR_TGT = 32'h0000_0200;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_valid_i;
    logic [XLEN-1:0] mem_pc_i, mem_addr_i;
    logic [31:0] mem_inst_i;
    logic exc_illegal_i, exc_ecall_i, exc_ebreak_i, exc_ld_mis_i;
    logic exc_st_mis_i, exc_ld_flt_i, exc_st_flt_i;
    logic mret_i, ext_irq_i, tmr_irq_i, csr_w_i;
    logic [XLEN-1:0] mstatus_i, mtvec_i, csr_mepc_i, csr_mcause_i, csr_mtval_i;
    logic is_trap_o, is_mret_o, stall_o, flush_o, redirect_o, busy_o;
    logic [XLEN-1:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .mem_inst_i(mem_inst_i), .mem_addr_i(mem_addr_i),
        .exc_illegal_i(exc_illegal_i), .exc_ecall_i(exc_ecall_i),
        .exc_ebreak_i(exc_ebreak_i), .exc_ld_mis_i(exc_ld_mis_i),
        .exc_st_mis_i(exc_st_mis_i), .exc_ld_flt_i(exc_ld_flt_i),
        .exc_st_flt_i(exc_st_flt_i), .mret_i(mret_i),
        .ext_irq_i(ext_irq_i), .tmr_irq_i(tmr_irq_i), .csr_w_i(csr_w_i),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mcause_i(csr_mcause_i), .csr_mtval_i(csr_mtval_i),
        .is_trap_o(is_trap_o), .is_mret_o(is_mret_o),
        .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
        .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // exc bits: illegal, ebreak, ecall, ld_mis, st_mis, ld_flt, st_flt
    typedef struct {
        logic        valid;
        logic [6:0]  exc;
        logic        mret;
        logic        ext;
        logic        tmr;
        logic [31:0] mstatus;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] mtvec;
        logic [1:0]  kind;
        logic [31:0] e_mepc;
        logic [31:0] e_cause;
        logic [31:0] e_tval;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] mepc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] tgt;
    } exp_t;

    vec_t vecs[19];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_valid_i = 1'b0;
        mem_pc_i = '0; mem_inst_i = '0; mem_addr_i = '0;
        {exc_illegal_i, exc_ebreak_i, exc_ecall_i, exc_ld_mis_i,
         exc_st_mis_i, exc_ld_flt_i, exc_st_flt_i} = 7'b0;
        mret_i = 1'b0; ext_irq_i = 1'b0; tmr_irq_i = 1'b0;
        csr_w_i = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        mem_valid_i = v.valid;
        mem_pc_i = v.pc; mem_inst_i = v.inst; mem_addr_i = v.addr;
        {exc_illegal_i, exc_ebreak_i, exc_ecall_i, exc_ld_mis_i,
         exc_st_mis_i, exc_ld_flt_i, exc_st_flt_i} = v.exc;
        mret_i = v.mret; ext_irq_i = v.ext; tmr_irq_i = v.tmr;
        mstatus_i = v.mstatus; mtvec_i = v.mtvec;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 10 && busy_o; k++) @(negedge clk);
        if (busy_o) check({name, "_idle_timeout"}, 32'(busy_o), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        logic [1:0] got;
        int nflush;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        drive_vec(v);
        exp_q.push_back('{v.kind, v.e_mepc, v.e_cause, v.e_tval, v.e_tgt});
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.kind == K_NONE) begin
            clear_inputs();
            #1;
            check({nm, "_no_event_busy"}, 32'(busy_o), 32'd0);
            check({nm, "_no_event_strobe"}, 32'({is_trap_o, is_mret_o}), 32'd0);
            return;
        end
        for (int k = 0; k < 4 && !(is_trap_o || is_mret_o); k++) @(negedge clk);
        got = is_mret_o ? K_MRET : (is_trap_o ? K_TRAP : K_NONE);
        check({nm, "_kind"}, 32'(got), 32'(e.kind));
        check({nm, "_mepc"}, mepc_o, e.mepc);
        check({nm, "_mcause"}, mcause_o, e.cause);
        check({nm, "_mtval"}, mtval_o, e.tval);
        check({nm, "_stall_flush"}, 32'({stall_o, flush_o, redirect_o}), 32'b110);
        clear_inputs();
        @(negedge clk);
        if (e.kind == K_MRET) begin
            // Target must come from the value latched when MRET exited.
            csr_mepc_i = 32'hDEAD_BEE0;
            #1;
        end
        check({nm, "_redir"}, 32'({redirect_o, flush_o, stall_o, is_trap_o, is_mret_o}),
              32'b11000);
        check({nm, "_redir_pc"}, redirect_pc_o, e.tgt);
        csr_mepc_i = 32'h0000_0104;
        nflush = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            if (flush_o && !redirect_o) nflush++;
        end
        check({nm, "_flush_cycles"}, 32'(nflush), 32'(FLUSH_CYCLES));
        wait_idle(nm);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 7'b1000000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h200,
                     K_TRAP, 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h200};
        vecs[1]  = '{1'b1, 7'b1001000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h104, 32'h1234_5678, 32'h55, 32'h200,
                     K_TRAP, 32'h104, 32'd2, 32'h1234_5678, 32'h200};
        vecs[2]  = '{1'b1, 7'b0100000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h140, 32'h0010_0073, 32'h9, 32'h400,
                     K_TRAP, 32'h140, 32'd3, 32'h140, 32'h400};
        vecs[3]  = '{1'b1, 7'b0010000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h144, 32'h0000_0073, 32'h9, 32'h200,
                     K_TRAP, 32'h144, 32'd11, 32'h0, 32'h200};
        vecs[4]  = '{1'b1, 7'b0001000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h148, 32'h0000_2003, 32'h1003, 32'h200,
                     K_TRAP, 32'h148, 32'd4, 32'h1003, 32'h200};
        vecs[5]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h14C, 32'h0000_2023, 32'h2002, 32'h200,
                     K_TRAP, 32'h14C, 32'd6, 32'h2002, 32'h200};
        vecs[6]  = '{1'b1, 7'b0000010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h150, 32'h0000_2003, 32'h3000, 32'h200,
                     K_TRAP, 32'h150, 32'd5, 32'h3000, 32'h200};
        vecs[7]  = '{1'b1, 7'b0000001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h154, 32'h0000_2023, 32'h4000, 32'h200,
                     K_TRAP, 32'h154, 32'd7, 32'h4000, 32'h200};
        vecs[8]  = '{1'b1, 7'b0000000, 1'b0, 1'b1, 1'b0, 32'h80, 32'h158, 32'h13, 32'h0, 32'h200,
                     K_NONE, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 7'b0000000, 1'b0, 1'b1, 1'b0, 32'h88, 32'h158, 32'h13, 32'h77, 32'h200,
                     K_TRAP, 32'h158, 32'h8000_000B, 32'h0, 32'h200};
        vecs[10] = '{1'b1, 7'b0000000, 1'b0, 1'b0, 1'b1, 32'h88, 32'h15C, 32'h13, 32'h77, 32'h201,
                     K_TRAP, 32'h15C, 32'h8000_0007, 32'h0, VEC_TMR_TGT};
        vecs[11] = '{1'b1, 7'b0010000, 1'b0, 1'b0, 1'b0, 32'h88, 32'h160, 32'h73, 32'h0, 32'h201,
                     K_TRAP, 32'h160, 32'd11, 32'h0, 32'h200};
        vecs[12] = '{1'b1, 7'b0000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h164, 32'h3020_0073, 32'h0, 32'h200,
                     K_MRET, 32'h104, 32'h55, 32'h66, 32'h104};
        vecs[13] = '{1'b1, 7'b0000000, 1'b1, 1'b0, 1'b1, 32'h88, 32'h164, 32'h3020_0073, 32'h0, 32'h200,
                     K_MRET, 32'h104, 32'h55, 32'h66, 32'h104};
        vecs[14] = '{1'b1, 7'b0010000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h168, 32'h73, 32'h0, 32'h200,
                     K_TRAP, 32'h168, 32'd11, 32'h0, 32'h200};
        vecs[15] = '{1'b1, 7'b0000000, 1'b0, 1'b1, 1'b1, 32'h88, 32'h16C, 32'h13, 32'h0, 32'h200,
                     K_TRAP, 32'h16C, 32'h8000_000B, 32'h0, 32'h200};
        vecs[16] = '{1'b0, 7'b1000000, 1'b0, 1'b0, 1'b0, 32'h88, 32'h170, 32'hFFFF_FFFF, 32'h0, 32'h200,
                     K_NONE, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[17] = '{1'b1, 7'b0001001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h170, 32'h3, 32'h7, 32'h200,
                     K_TRAP, 32'h170, 32'd4, 32'h7, 32'h200};
        vecs[18] = '{1'b1, 7'b1000000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h174, 32'h0, 32'h0, 32'h203,
                     K_TRAP, 32'h174, 32'd2, 32'h0, 32'h200};

        rst = 1'b1;
        clear_inputs();
        mstatus_i = '0; mtvec_i = 32'h200;
        csr_mepc_i = 32'h104; csr_mcause_i = 32'h55; csr_mtval_i = 32'h66;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'({is_trap_o, is_mret_o, stall_o, flush_o, redirect_o, busy_o}), 32'd0);
        check("reset_data", mepc_o | mcause_o | mtval_o | redirect_pc_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        // csr_w collision: strobe held 3 cycles, redirect 2 cycles late.
        @(negedge clk);
        mem_valid_i = 1'b1; exc_ecall_i = 1'b1; mem_pc_i = 32'h300;
        mstatus_i = '0; mtvec_i = 32'h200;
        @(negedge clk);
        clear_inputs();
        csr_w_i = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("coll_trap_c%0d", c), 32'({is_trap_o, redirect_o}), 32'b10);
            check($sformatf("coll_vals_c%0d", c), mepc_o ^ mcause_o, 32'h300 ^ 32'd11);
            @(negedge clk);
            if (c == 1) csr_w_i = 1'b0;
            #1;
        end
        check("coll_redir", 32'({is_trap_o, redirect_o}), 32'b01);
        check("coll_redir_pc", redirect_pc_o, 32'h200);
        wait_idle("coll");

        // csr_w collision during MRET also holds the strobe.
        @(negedge clk);
        mem_valid_i = 1'b1; mret_i = 1'b1;
        @(negedge clk);
        clear_inputs();
        csr_w_i = 1'b1;
        @(negedge clk);
        check("mret_coll_hold", 32'({is_mret_o, redirect_o}), 32'b10);
        csr_w_i = 1'b0;
        @(negedge clk);
        check("mret_coll_redir", redirect_pc_o, 32'h104);
        wait_idle("mret_coll");

        // Reset while in TRAP: nothing left over, later ecall traps normally.
        @(negedge clk);
        mem_valid_i = 1'b1; exc_illegal_i = 1'b1; mem_pc_i = 32'h400; mem_inst_i = 32'hABCD;
        @(negedge clk);
        clear_inputs();
        check("rst_pre_trap", 32'(is_trap_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", 32'({is_trap_o, is_mret_o, stall_o, flush_o, redirect_o, busy_o}), 32'd0);
        check("rst_mid_data", mepc_o | mcause_o | mtval_o | redirect_pc_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_idle", 32'(busy_o), 32'd0);
        begin
            vec_t v;
            v = '{1'b1, 7'b0010000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h408, 32'h73, 32'h0, 32'h200,
                  K_TRAP, 32'h408, 32'd11, 32'h0, 32'h200};
            run_vec(99, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences trap entry and trap return for the M-mode-only core.
- Samples exception flags, `mret` and the interrupt lines from the MEM stage, then picks one event by fixed priority.
- Drives the CSR register file's trap/mret update port (`is_trap`, `is_mret`, `mepc`, `mcause`, `mtval`), then flushes the pipeline and redirects fetch to `mtvec` or `mepc`.

Parameters:
- `XLEN`, 32, data/address width.
- `FLUSH_CYCLES`, 1, extra flush cycles held after the redirect (0..3).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid_i`  in  1  MEM stage holds a live instruction.
- `mem_pc_i`  in  XLEN  PC of the MEM instruction.
- `mem_inst_i`  in  32  encoding of the MEM instruction.
- `mem_addr_i`  in  XLEN  load/store effective address.
- `exc_illegal_i`, `exc_ecall_i`, `exc_ebreak_i`, `exc_ld_mis_i`, `exc_st_mis_i`, `exc_ld_flt_i`, `exc_st_flt_i`  in  1 each  exception flags.
- `mret_i`  in  1  MEM instruction is `mret`.
- `ext_irq_i`, `tmr_irq_i`  in  1 each  level interrupts.
- `csr_w_i`  in  1  a CSR instruction write is committing this cycle.
- `mstatus_i`, `mtvec_i`, `csr_mepc_i`, `csr_mcause_i`, `csr_mtval_i`  in  XLEN each  current CSR contents.
- `is_trap_o`, `is_mret_o`  out  1 each  CSR update strobes.
- `mepc_o`, `mcause_o`, `mtval_o`  out  XLEN each  values written into the CSRs.
- `stall_o`  out  1  freeze IF..MEM.
- `flush_o`  out  1  kill IF..MEM.
- `redirect_o`  out  1  load `redirect_pc_o` into the PC.
- `redirect_pc_o`  out  XLEN  fetch target.
- `busy_o`  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: all state changes on the rising edge of `clk`. Reset is synchronous, active-high: state=IDLE, every output 0.
- States: IDLE, TRAP, MRET, REDIR, FLUSH.
- IDLE, event selection (only when `mem_valid_i`=1), highest priority first:
  - `exc_illegal` → cause 2, tval = `mem_inst_i`.
  - `exc_ebreak` → cause 3, tval = `mem_pc_i`.
  - `exc_ecall` → cause 11, tval = 0.
  - `exc_ld_mis` → cause 4, tval = addr.
  - `exc_st_mis` → cause 6, tval = addr.
  - `exc_ld_flt` → cause 5, tval = addr.
  - `exc_st_flt` → cause 7, tval = addr.
  - `mret_i` → MRET.
  - `ext_irq_i` and `mstatus_i[3]` → cause 0x8000000B, tval = 0.
  - `tmr_irq_i` and `mstatus_i[3]` → cause 0x80000007, tval = 0.
- On an exception or interrupt: register mepc = `mem_pc_i`, cause and tval; go to TRAP.
- With no event, or `mem_valid_i`=0: stay in IDLE, all outputs 0. Interrupts are ignored outside IDLE and while MIE=0.
- TRAP:
  - Outputs: `is_trap_o`=1, `stall_o`=1, `flush_o`=1, `mepc_o`/`mcause_o`/`mtval_o` = registered values.
  - If `csr_w_i`=1, stay in TRAP with the strobe held. The CSR file gives priority to CSR-instruction writes, so the trap retries the next cycle.
  - Otherwise go to REDIR.
- MRET:
  - Outputs: `is_mret_o`=1, `stall_o`=1, `flush_o`=1.
  - `mepc_o`/`mcause_o`/`mtval_o` echo `csr_mepc_i`/`csr_mcause_i`/`csr_mtval_i` so the CSR contents are preserved.
  - `csr_w_i` hold rule is the same as TRAP. The redirect target `csr_mepc_i` is latched on exit; go to REDIR.
- REDIR:
  - Outputs: `redirect_o`=1, `flush_o`=1.
  - Target: the latched mepc after MRET; after TRAP, `{mtvec_i[XLEN-1:2],2'b00}`.
  - Go to FLUSH if `FLUSH_CYCLES`>0, else IDLE.
- FLUSH: `flush_o`=1 for `FLUSH_CYCLES` cycles (down-counter), then IDLE.
- Latency, event detection to redirect: 2 cycles when no `csr_w` collision; each colliding cycle adds 1.
- `busy_o` = (state≠IDLE).
- Reset in any state returns to IDLE next edge; no strobe is emitted.

Optional Feature:
- Macro: `TRAP_CTRL_VECTORED_EN`.
- Defined: when `mtvec_i[1:0]`==2'b01 and the trap is an interrupt, REDIR target = base + 4×(cause[30:0]); exceptions always use base.
- Undefined: `mtvec_i[1:0]` is ignored and every trap targets base (direct mode).

Decomposition:
- Shared package `trap_pkg` holds:
  - the cause codes (`CAUSE_ILLEGAL`=2, `CAUSE_EBREAK`=3, `CAUSE_LD_MIS`=4, `CAUSE_LD_FLT`=5, `CAUSE_ST_MIS`=6, `CAUSE_ST_FLT`=7, `CAUSE_ECALL_M`=11, `CAUSE_M_TIMER`=0x80000007, `CAUSE_M_EXT`=0x8000000B);
  - the FSM state enum;
  - the `MSTATUS_MIE` bit index (3).
- One sub-module, `trap_prio_enc`: a combinational priority encoder that takes the flag set and returns {hit, cause, tval_sel}.

Test Plan:
- Illegal instruction at pc=0x100, inst=0xFFFFFFFF, mtvec=0x200 → TRAP 1 cycle later with mepc=0x100, mcause=2, mtval=0xFFFFFFFF; next cycle `redirect_o`=1, pc=0x200.
- `exc_ld_mis` and `exc_illegal` together → mcause=2. `ext_irq_i` with `mstatus_i`=0x80 (MIE=0) → no trap; with 0x88 → mcause=0x8000000B.
- `mret_i` with `csr_mepc_i`=0x104 → `is_mret_o` 1 cycle; `mepc_o`/`mcause_o`/`mtval_o` equal the CSR inputs; redirect to 0x104.
- `csr_w_i` high for 2 cycles during TRAP → `is_trap_o` held 3 cycles, redirect delayed 2 cycles, values unchanged.
- `rst` asserted while in TRAP → next cycle all outputs 0, state IDLE; a later ecall traps normally (mcause=11).
- With `TRAP_CTRL_VECTORED_EN`, mtvec=0x201, timer irq → redirect 0x21C; ecall → 0x200.
